// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel pipeline: stream field map, widths
// and the default SVGA 800x600@72 timing.
package vga_pkg;

    localparam int STREAM_W     = 23;
    localparam int STREAM_RGB_W = 26;

    localparam int ACTIVE_BIT = 0;
    localparam int VS_BIT     = 1;
    localparam int HS_BIT     = 2;
    localparam int YC_LSB     = 3;
    localparam int YC_MSB     = 12;
    localparam int XC_LSB     = 13;
    localparam int XC_MSB     = 22;
    localparam int R_BIT      = 23;
    localparam int G_BIT      = 24;
    localparam int B_BIT      = 25;

    localparam int HCNT_W  = 11;
    localparam int VCNT_W  = 10;
    localparam int COORD_W = 10;
    localparam int FCNT_W  = 8;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 56;
    localparam int SVGA_H_SYNC   = 120;
    localparam int SVGA_H_BP     = 64;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 37;
    localparam int SVGA_V_SYNC   = 6;
    localparam int SVGA_V_BP     = 23;

    // Half-open window test lo <= pos < hi, used for sync pulse decode.
    function automatic logic in_window(input logic [15:0] pos,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MOD up counter with a count enable; wrap is high in the cycle the
// counter is enabled while sitting on its last value.
module vga_axis_counter #(
    parameter int W   = 11,
    parameter int MOD = 1040
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic at_last;

    assign at_last = (cnt == LAST);
    assign wrap    = en && at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_stream.sv
// Free-running VGA timing generator: counters, sync/active decode and a
// registered strVGA bundle with frame-end pulse and frame counter.
module vga_sync_stream
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic                px_clk,
    input  logic                reset,
    output logic [STREAM_W-1:0] strVGA,
    output logic                endframe,
    output logic [FCNT_W-1:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              h_wrap;
    logic              v_wrap;

    logic              active_d;
    logic              hs_d;
    logic              vs_d;

    vga_axis_counter #(
        .W   (HCNT_W),
        .MOD (H_TOTAL)
    ) u_hcnt (
        .clk   (px_clk),
        .reset (reset),
        .en    (1'b1),
        .cnt   (hcnt),
        .wrap  (h_wrap)
    );

    // v_wrap only fires when both axes sit on their last value: the frame's final pixel.
    vga_axis_counter #(
        .W   (VCNT_W),
        .MOD (V_TOTAL)
    ) u_vcnt (
        .clk   (px_clk),
        .reset (reset),
        .en    (h_wrap),
        .cnt   (vcnt),
        .wrap  (v_wrap)
    );

    always_comb begin
        active_d = (hcnt < HCNT_W'(H_ACTIVE)) && (vcnt < VCNT_W'(V_ACTIVE));
        hs_d     = in_window(16'(hcnt), HS_START, HS_END) ? HS_POL : ~HS_POL;
        vs_d     = in_window(16'(vcnt), VS_START, VS_END) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            strVGA             <= '0;
            strVGA[HS_BIT]     <= ~HS_POL;
            strVGA[VS_BIT]     <= ~VS_POL;
            endframe           <= 1'b0;
            frame_cnt          <= '0;
        end else begin
            strVGA[ACTIVE_BIT]     <= active_d;
            strVGA[HS_BIT]         <= hs_d;
            strVGA[VS_BIT]         <= vs_d;
            strVGA[YC_MSB:YC_LSB]  <= vcnt;
            strVGA[XC_MSB:XC_LSB]  <= hcnt[COORD_W-1:0];
            endframe               <= v_wrap;
            // Counted as the stream steps from the last pixel onto (0,0).
            if (endframe) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_stream.sv
// Randomised and directed bench for vga_sync_stream against a pixel-index
// reference model (output index k -> coordinates, syncs, frame count).
module tb_vga_sync_stream;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs_small = 1'b1, rs_neg = 1'b1, rs_def = 1'b1, rs_med = 1'b1;
    logic [22:0] s_small, s_neg, s_def, s_med;
    logic        ef_small, ef_neg, ef_def, ef_med;
    logic [7:0]  fc_small, fc_neg, fc_def, fc_med;

    int vectors = 0;
    int fails   = 0;
    cfg_t c_small, c_neg, c_def, c_med;

    vga_sync_stream #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_small (
        .px_clk(clk), .reset(rs_small), .strVGA(s_small), .endframe(ef_small), .frame_cnt(fc_small));

    vga_sync_stream #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                      .HS_POL(1'b0), .VS_POL(1'b0)) u_neg (
        .px_clk(clk), .reset(rs_neg), .strVGA(s_neg), .endframe(ef_neg), .frame_cnt(fc_neg));

    vga_sync_stream u_def (
        .px_clk(clk), .reset(rs_def), .strVGA(s_def), .endframe(ef_def), .frame_cnt(fc_def));

    vga_sync_stream #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                      .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2)) u_med (
        .px_clk(clk), .reset(rs_med), .strVGA(s_med), .endframe(ef_med), .frame_cnt(fc_med));

    // k < 0 means the output register holds reset values; otherwise k is the
    // number of pixels emitted since reset release.
    function automatic logic [31:0] model(input cfg_t c, input int k);
        int ht, vt, x, y, f;
        logic [31:0] xv, yv, fv;
        logic act, hs, vs, ef;
        if (k < 0) return {8'd0, 1'b0, 20'd0, ~c.hp, ~c.vp, 1'b0};
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        x   = k % ht;
        y   = (k / ht) % vt;
        f   = (k / (ht * vt)) % 256;
        act = (x < c.ha) && (y < c.va);
        hs  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        vs  = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        ef  = (x == ht - 1) && (y == vt - 1);
        xv  = x;
        yv  = y;
        fv  = f;
        return {fv[7:0], ef, xv[9:0], yv[9:0], hs, vs, act};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rs_small = 1'b1;
        rs_neg   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({fc_small, ef_small, s_small} !== model(c_small, -1)) begin
                fails++;
                $display("FAIL reset_small got=%h exp=%h", {fc_small, ef_small, s_small}, model(c_small, -1));
            end
            vectors++;
            if ({fc_neg, ef_neg, s_neg} !== model(c_neg, -1)) begin
                fails++;
                $display("FAIL reset_neg got=%h exp=%h", {fc_neg, ef_neg, s_neg}, model(c_neg, -1));
            end
            vectors++;
            if (s_neg[2:1] !== 2'b11) begin
                fails++;
                $display("FAIL reset_neg_syncs got=%b exp=11", s_neg[2:1]);
            end
        end
    endtask

    task automatic test_small_frames();
        int k = 0, last_ef = -1, n_ef = 0;
        rs_small = 1'b0;
        for (int i = 0; i < 2 * 48 + 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_small, ef_small, s_small} !== model(c_small, k)) begin
                fails++;
                $display("FAIL small_stream k=%0d got=%h exp=%h", k, {fc_small, ef_small, s_small}, model(c_small, k));
            end
            if (i == 0) begin
                vectors++;
                if (s_small !== 23'h000001) begin
                    fails++;
                    $display("FAIL small_first got=%h exp=000001", s_small);
                end
            end
            if (ef_small === 1'b1) begin
                if (last_ef >= 0) begin
                    vectors++;
                    if (i - last_ef != 48) begin
                        fails++;
                        $display("FAIL small_ef_period got=%0d exp=48", i - last_ef);
                    end
                end
                last_ef = i;
                n_ef++;
            end
            k++;
        end
        vectors++;
        if (n_ef != 2) begin
            fails++;
            $display("FAIL small_ef_count got=%0d exp=2", n_ef);
        end
    endtask

    task automatic test_polarity();
        int k = 0, hs_low = 0, vs_low = 0;
        rs_neg = 1'b0;
        for (int i = 0; i < 2 * 48; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_neg, ef_neg, s_neg} !== model(c_neg, k)) begin
                fails++;
                $display("FAIL neg_stream k=%0d got=%h exp=%h", k, {fc_neg, ef_neg, s_neg}, model(c_neg, k));
            end
            if (i < 48 && s_neg[2] === 1'b0) hs_low++;
            if (i < 48 && s_neg[1] === 1'b0) vs_low++;
            k++;
        end
        vectors++;
        if (hs_low != 12 || vs_low != 8) begin
            fails++;
            $display("FAIL neg_pulse_widths got=%0d/%0d exp=12/8", hs_low, vs_low);
        end
    endtask

    task automatic test_default_lines();
        int k = 0, hs_n = 0, hs_first = -1;
        rs_def = 1'b0;
        for (int i = 0; i < 3 * 1040 + 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_def, ef_def, s_def} !== model(c_def, k)) begin
                fails++;
                $display("FAIL def_stream k=%0d got=%h exp=%h", k, {fc_def, ef_def, s_def}, model(c_def, k));
            end
            if (i < 1040 && s_def[2] === 1'b1) begin
                if (hs_first < 0) hs_first = i;
                hs_n++;
            end
            if (i == 1024) begin
                vectors++;
                if (s_def[22:13] !== 10'd0 || s_def[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL def_xc_alias got=%0d/%b exp=0/0", s_def[22:13], s_def[0]);
                end
            end
            k++;
        end
        vectors++;
        if (hs_first != 856 || hs_n != 120) begin
            fails++;
            $display("FAIL def_hs_window got=%0d+%0d exp=856+120", hs_first, hs_n);
        end
    endtask

    task automatic test_frame_period();
        int k = 0, last_ef = -1, n_ef = 0;
        @(negedge clk);
        rs_med = 1'b1;
        @(negedge clk);
        rs_med = 1'b0;
        for (int i = 0; i < 3 * 544 + 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_med, ef_med, s_med} !== model(c_med, k)) begin
                fails++;
                $display("FAIL med_stream k=%0d got=%h exp=%h", k, {fc_med, ef_med, s_med}, model(c_med, k));
            end
            if (ef_med === 1'b1) begin
                if (last_ef >= 0) begin
                    vectors++;
                    if (i - last_ef != 544) begin
                        fails++;
                        $display("FAIL med_ef_period got=%0d exp=544", i - last_ef);
                    end
                end
                last_ef = i;
                n_ef++;
            end
            k++;
        end
        vectors++;
        if (n_ef != 3) begin
            fails++;
            $display("FAIL med_ef_count got=%0d exp=3", n_ef);
        end
    endtask

    task automatic test_mid_reset();
        int k = -1;
        bit done = 1'b0;
        logic r;
        @(negedge clk);
        rs_small = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_small, ef_small, s_small} !== model(c_small, k)) begin
                fails++;
                $display("FAIL midrst_stream k=%0d got=%h exp=%h", k, {fc_small, ef_small, s_small}, model(c_small, k));
            end
            if (done && k == -1) begin
                vectors++;
                if (s_small !== 23'd0 || ef_small !== 1'b0 || fc_small !== 8'd0) begin
                    fails++;
                    $display("FAIL midrst_values got=%h/%b/%0d exp=0/0/0", s_small, ef_small, fc_small);
                end
            end
            r = (k == 10 && !done);  // output showing (2,1)
            if (r) done = 1'b1;
            rs_small = r;
            k = r ? -1 : k + 1;
        end
    endtask

    task automatic test_random_reset();
        int k = -1;
        logic r;
        @(negedge clk);
        rs_med = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_med, ef_med, s_med} !== model(c_med, k)) begin
                fails++;
                $display("FAIL rand_stream k=%0d got=%h exp=%h", k, {fc_med, ef_med, s_med}, model(c_med, k));
            end
            r = ($urandom_range(0, 299) == 0);
            rs_med = r;
            k = r ? -1 : k + 1;
        end
    endtask

    task automatic test_frame_wrap();
        int k = -1;
        @(negedge clk);
        rs_small = 1'b1;
        for (int i = 0; i < 256 * 48 + 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({fc_small, ef_small, s_small} !== model(c_small, k)) begin
                fails++;
                $display("FAIL wrap_stream k=%0d got=%h exp=%h", k, {fc_small, ef_small, s_small}, model(c_small, k));
            end
            if (k == 256 * 48 - 1) begin
                vectors++;
                if (fc_small !== 8'd255 || ef_small !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_last got=%0d/%b exp=255/1", fc_small, ef_small);
                end
            end
            if (k == 256 * 48) begin
                vectors++;
                if (fc_small !== 8'd0 || s_small !== 23'h000001) begin
                    fails++;
                    $display("FAIL wrap_zero got=%0d/%h exp=0/000001", fc_small, s_small);
                end
            end
            rs_small = 1'b0;
            k++;
        end
    endtask

    initial begin
        c_small = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1, hp: 1'b1, vp: 1'b1};
        c_neg   = '{ha: 4, hf: 1, hs: 2, hb: 1, va: 3, vf: 1, vs: 1, vb: 1, hp: 1'b0, vp: 1'b0};
        c_def   = '{ha: 800, hf: 56, hs: 120, hb: 64, va: 600, vf: 37, vs: 6, vb: 23, hp: 1'b1, vp: 1'b1};
        c_med   = '{ha: 20, hf: 3, hs: 5, hb: 4, va: 10, vf: 2, vs: 3, vb: 2, hp: 1'b1, vp: 1'b1};
        repeat (2) @(negedge clk);
        test_reset();
        test_small_frames();
        test_polarity();
        test_default_lines();
        test_frame_period();
        test_mid_reset();
        test_random_reset();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
